// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The FETCH_BRANCH_EN macro (see fetch_ctrl.sv) selects whether branch words are decoded.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DELIVER,
    UPDATE,
    HALT
  } state_e;

  localparam logic [2:0]  BR_OPCODE = 3'b110;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;
  localparam int          BR_IMM_W  = 12;

endpackage

// File: rtl/fetch_branch_dec.sv
// Combinational branch decoder: recognises relative-branch words and extracts direction and distance.
// Instantiated by fetch_ctrl only when FETCH_BRANCH_EN is defined.
module fetch_branch_dec
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] instr,
  output logic              is_branch,
  output logic              dir,
  output logic [ADDR_W-1:0] offset
);

  always_comb begin
    is_branch = (instr[DATA_W-1 -: 3] == BR_OPCODE);
    // dir=0 steps forward (add), dir=1 steps backward (sub).
    dir       = instr[DATA_W-4];
    offset    = ADDR_W'(instr[BR_IMM_W-1:0]);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: reads the PC, fetches from memory, hands the word to decode, steps the PC.
// Define FETCH_BRANCH_EN to decode relative branches; otherwise every non-halt word steps with inc.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              inc,
  output logic              add,
  output logic              sub,
  output logic [ADDR_W-1:0] offset,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic              br_hit;
  logic              br_dir;
  logic [ADDR_W-1:0] br_offset;

`ifdef FETCH_BRANCH_EN
  fetch_branch_dec #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_branch_dec (
    .instr     (instr_q),
    .is_branch (br_hit),
    .dir       (br_dir),
    .offset    (br_offset)
  );
`else
  assign br_hit    = 1'b0;
  assign br_dir    = 1'b0;
  assign br_offset = '0;
`endif

  // NOTE: defaults first, so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (mem_req_ready) begin
          req_addr_d = pc;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // Responses are only honoured here, so stale data after a reset is dropped.
        if (mem_rsp_valid) begin
          instr_d    = mem_rsp_data;
          instr_pc_d = req_addr_q;
          state_d    = DELIVER;
        end
      end
      DELIVER: begin
        if (instr_ready) begin
          state_d = (instr_q == DATA_W'(HALT_WORD)) ? HALT : UPDATE;
        end
      end
      UPDATE:  state_d = REQ;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Outputs depend only on registered state; pc is passed straight through while requesting.
  always_comb begin
    mem_req_valid = (state_q == REQ);
    mem_req_addr  = (state_q == REQ) ? pc : '0;
    instr_valid   = (state_q == DELIVER);
    instr         = instr_q;
    instr_pc      = instr_pc_q;
    halted        = (state_q == HALT);
    inc           = (state_q == UPDATE) && !br_hit;
    add           = (state_q == UPDATE) && br_hit && !br_dir;
    sub           = (state_q == UPDATE) && br_hit && br_dir;
    offset        = ((state_q == UPDATE) && br_hit) ? br_offset : '0;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: PC unit and memory slave models, vector table,
// hand-written stall/halt/reset sequences and a randomized run against a reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc;
  logic        inc, add, sub;
  logic [15:0] offset;
  logic        mem_req_valid;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fetch_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .inc           (inc),
    .add           (add),
    .sub           (sub),
    .offset        (offset),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .halted        (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- PC unit (environment) ----------------
  logic [15:0] pc_rst_val = '0;
  always @(posedge clk or negedge reset) begin
    if (!reset)   pc <= pc_rst_val;
    else if (inc) pc <= pc + 16'd1;
    else if (add) pc <= pc + offset;
    else if (sub) pc <= pc - offset;
  end

  // ---------------- memory slave and decode-side ready ----------------
  logic [15:0] mem [logic [15:0]];
  int  stall_cfg = 0, lat_cfg = 0, ir_cfg = 0;
  int  stall_left = 0, lat_cnt = 0, ir_left = 0;
  bit  rand_mode = 0, pending = 0, acc_flag = 0;
  logic [15:0] pdata = '0;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0001;
  endfunction

  function automatic int pick(input int cfg, input int mx);
    return rand_mode ? int'($urandom_range(0, mx)) : cfg;
  endfunction

  // Inputs change 2 time units after the rising edge; the bench samples on the falling edge.
  always begin
    @(posedge clk);
    #2;
    if (acc_flag) begin
      pending  = 1;
      lat_cnt  = pick(lat_cfg, 3);
      acc_flag = 0;
    end
    mem_rsp_valid = 1'b0;
    if (pending) begin
      if (lat_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pdata;
        pending       = 0;
      end else begin
        lat_cnt--;
      end
    end
    mem_req_ready = 1'b0;
    if (mem_req_valid) begin
      if (stall_left > 0) stall_left--;
      else begin
        mem_req_ready = 1'b1;
        acc_flag      = 1;
        pdata         = mem_rd(mem_req_addr);
        stall_left    = pick(stall_cfg, 3);
      end
    end
    instr_ready = 1'b0;
    if (instr_valid) begin
      if (ir_left > 0) ir_left--;
      else begin
        instr_ready = 1'b1;
        ir_left     = pick(ir_cfg, 2);
      end
    end
  end

  // ---------------- protocol invariants ----------------
  bit          prev_stall = 0, prev_hold = 0;
  logic [15:0] prev_addr = '0, prev_instr = '0, prev_ipc = '0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 0;
      prev_hold  = 0;
    end else begin
      check("pulse_onehot", 32'($countones({inc, add, sub}) <= 1), 1);
      if (prev_stall) begin
        check("req_hold_valid", 32'(mem_req_valid), 1);
        check("req_hold_addr", mem_req_addr, prev_addr);
      end
      if (prev_hold) begin
        check("instr_hold_valid", 32'(instr_valid), 1);
        check("instr_hold_word", instr, prev_instr);
        check("instr_hold_pc", instr_pc, prev_ipc);
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
      prev_hold  = instr_valid && !instr_ready;
      prev_instr = instr;
      prev_ipc   = instr_pc;
    end
  end

  // ---------------- reference model ----------------
  // Expected {inc,add,sub}, offset and the following fetch address for word w fetched at p.
  function automatic void ref_step(input logic [15:0] p, input logic [15:0] w,
                                   output logic [2:0] ops, output logic [15:0] off,
                                   output logic [15:0] nxt);
    ops = 3'b100;
    off = 16'h0000;
    nxt = 16'((int'(p) + 1) % 65536);
`ifdef FETCH_BRANCH_EN
    if (w[15:13] == 3'b110) begin
      int dist;
      dist = int'(w[11:0]);
      off  = 16'(dist);
      if (w[12]) begin
        ops = 3'b001;
        nxt = 16'((int'(p) - dist + 65536) % 65536);
      end else begin
        ops = 3'b010;
        nxt = 16'((int'(p) + dist) % 65536);
      end
    end
`endif
  endfunction

  // ---------------- helpers ----------------
  function automatic logic sig(input int w);
    case (w)
      0:       return mem_req_valid;
      1:       return instr_valid;
      2:       return inc | add | sub;
      default: return halted;
    endcase
  endfunction

  task automatic wait_for(input int w, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(w) && n < 100);
    check({"wait_", name}, 32'(sig(w)), 1);
  endtask

  task automatic do_reset(input logic [15:0] start, input int s, input int l, input int ir);
    @(negedge clk);
    #1;
    pc_rst_val = start;
    reset      = 1'b0;
    stall_cfg  = s;  stall_left = s;
    lat_cfg    = l;
    ir_cfg     = ir; ir_left    = ir;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [15:0] pc0;
    logic [15:0] word;
    logic [2:0]  ops;
    logic [15:0] off;
    logic [15:0] nxt;
  } vec_t;

  localparam logic [2:0] P_INC = 3'b100, P_ADD = 3'b010, P_SUB = 3'b001;

  function automatic vec_t mk(input logic [15:0] p, input logic [15:0] w, input logic [2:0] o,
                              input logic [15:0] f, input logic [15:0] n);
    vec_t v;
    v.pc0 = p; v.word = w; v.ops = o; v.off = f; v.nxt = n;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    int          last, n;
    logic [15:0] a0, w, model_pc, e_off, e_nxt;
    logic [2:0]  e_ops;

`ifdef FETCH_BRANCH_EN
    vecs[0] = mk(16'h0002, 16'hC0A5, P_ADD, 16'h00A5, 16'h00A7);
    vecs[1] = mk(16'h0030, 16'hD014, P_SUB, 16'h0014, 16'h001C);
    vecs[3] = mk(16'h0010, 16'hC000, P_ADD, 16'h0000, 16'h0010);
    vecs[4] = mk(16'h0005, 16'hDFFF, P_SUB, 16'h0FFF, 16'hF006);
    vecs[7] = mk(16'h0003, 16'hD004, P_SUB, 16'h0004, 16'hFFFF);
`else
    vecs[0] = mk(16'h0002, 16'hC0A5, P_INC, 16'h0000, 16'h0003);
    vecs[1] = mk(16'h0030, 16'hD014, P_INC, 16'h0000, 16'h0031);
    vecs[3] = mk(16'h0010, 16'hC000, P_INC, 16'h0000, 16'h0011);
    vecs[4] = mk(16'h0005, 16'hDFFF, P_INC, 16'h0000, 16'h0006);
    vecs[7] = mk(16'h0003, 16'hD004, P_INC, 16'h0000, 16'h0004);
`endif
    vecs[2] = mk(16'hFFFF, 16'h0001, P_INC, 16'h0000, 16'h0000);
    vecs[5] = mk(16'h0100, 16'hE000, P_INC, 16'h0000, 16'h0101);
    vecs[6] = mk(16'h0200, 16'hA123, P_INC, 16'h0000, 16'h0201);

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({inc, add, sub, mem_req_valid, instr_valid, halted}), 0);
    check("rst_offset", offset, 0);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);

    // Linear fetch, zero-wait memory.
    mem.delete();
    do_reset(16'h0000, 0, 0, 0);
    last = 0;
    for (int k = 0; k < 3; k++) begin
      wait_for(0, "lin_req");
      check("lin_req_addr", mem_req_addr, 32'(k));
      wait_for(2, "lin_pulse");
      check("lin_ops", 32'({inc, add, sub}), 32'(P_INC));
      if (k > 0) check("lin_gap", 32'(cyc - last), 4);
      last = cyc;
    end

    // Single-instruction vectors.
    foreach (vecs[i]) begin
      mem.delete();
      mem[vecs[i].pc0] = vecs[i].word;
      do_reset(vecs[i].pc0, 0, 0, 0);
      wait_for(0, "vec_req");
      check("vec_req_addr", mem_req_addr, vecs[i].pc0);
      wait_for(1, "vec_instr");
      check("vec_instr", instr, vecs[i].word);
      check("vec_instr_pc", instr_pc, vecs[i].pc0);
      wait_for(2, "vec_pulse");
      check("vec_ops", 32'({inc, add, sub}), 32'(vecs[i].ops));
      check("vec_offset", offset, vecs[i].off);
      wait_for(0, "vec_next_req");
      check("vec_next_addr", mem_req_addr, vecs[i].nxt);
    end

    // Request stalled 3 cycles, decode stalled 2 cycles.
    mem.delete();
    mem[16'h0020] = 16'h1234;
    do_reset(16'h0020, 3, 0, 2);
    wait_for(0, "stall_req");
    a0 = mem_req_addr;
    n  = 1;
    while (n < 50) begin
      @(negedge clk);
      if (!mem_req_valid) break;
      n++;
    end
    check("stall_req_cycles", 32'(n), 4);
    check("stall_req_addr", a0, 16'h0020);
    wait_for(1, "stall_instr");
    n = 1;
    while (n < 50) begin
      check("stall_no_pulse", 32'({inc, add, sub}), 0);
      check("stall_instr_word", instr, 16'h1234);
      @(negedge clk);
      if (!instr_valid) break;
      n++;
    end
    check("stall_deliver_cycles", 32'(n), 3);
    check("stall_pulse_after", 32'({inc, add, sub}), 32'(P_INC));

    // Reset during WAIT, stale response arrives while the new request is stalled.
    mem.delete();
    mem[16'h0000] = 16'h0BAD;
    do_reset(16'h0000, 0, 6, 0);
    wait_for(0, "stale_req0");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("stale_async_ctrl", 32'({inc, add, sub, mem_req_valid, instr_valid, halted}), 0);
    check("stale_async_instr", instr, 0);
    stall_left = 8;
    mem[16'h0000] = 16'h1357;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_for(0, "stale_req1");
    check("stale_req_addr", mem_req_addr, 16'h0000);
    wait_for(1, "stale_instr");
    check("stale_instr", instr, 16'h1357);
    check("stale_instr_pc", instr_pc, 16'h0000);

    // Randomized run against the reference model.
    rand_mode = 1;
    model_pc  = 16'($urandom_range(0, 65535));
    mem.delete();
    do_reset(model_pc, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       w = {3'b110, 13'($urandom)};
        1:       w = 16'($urandom);
        default: w = 16'($urandom_range(0, 16'h1FFF));
      endcase
      if (w == 16'hFFFF) w = 16'hFFFE;
      mem[model_pc] = w;
      wait_for(0, "rnd_req");
      check("rnd_req_addr", mem_req_addr, model_pc);
      wait_for(1, "rnd_instr");
      check("rnd_instr", instr, w);
      check("rnd_instr_pc", instr_pc, model_pc);
      wait_for(2, "rnd_pulse");
      ref_step(model_pc, w, e_ops, e_off, e_nxt);
      check("rnd_ops", 32'({inc, add, sub}), 32'(e_ops));
      check("rnd_offset", offset, e_off);
      model_pc = e_nxt;
    end
    rand_mode = 0;

    // Halt word: no further requests, cleared asynchronously by reset.
    mem.delete();
    mem[16'h0040] = 16'hFFFF;
    do_reset(16'h0040, 0, 0, 0);
    wait_for(1, "halt_instr");
    check("halt_instr", instr, 16'hFFFF);
    wait_for(3, "halt_flag");
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req_valid || inc || add || sub || !halted) n++;
    end
    check("halt_quiet_cycles", 32'(n), 0);
    #2;
    reset = 1'b0;
    #1;
    check("halt_async_clear", 32'({halted, mem_req_valid, instr_valid}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
